morse_letter_tx: RTL and testbench
==================================

# morse_letter_tx

Parametrised Morse transmitter for the lab's bit-serial signalling path. It accepts a 5-bit letter code (A–Z) on a single-cycle `Start` strobe and emits the letter's on/off keying on `DotDashOut`, one symbol bit per bit period. It adds a busy/done handshake, a per-letter length (no fixed 12-bit frame), and a configurable bit rate. It sits between the switch/key front end and the LED/buzzer driver.

## Interface
- `CLOCK_FREQUENCY`, 500: input clock in Hz.
- `BITS_PER_SECOND`, 2: symbol bit rate. `DIV = CLOCK_FREQUENCY / BITS_PER_SECOND` clock cycles per bit. Elaboration fails if `DIV < 2`.
- `ClockIn` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: request to send `Letter`. Sampled every cycle.
- `Letter` in 5: 0 = A … 25 = Z. Codes 26–31 are invalid.
- `DotDashOut` out 1: keyed output; 1 = tone on.
- `NewBitOut` out 1: one-cycle pulse in the first cycle of each emitted bit.
- `Busy` out 1: high while a letter is in flight.
- `Done` out 1: one-cycle pulse when a letter completes.

## Operation
- Encoding:
  - dot = `1`, dash = `111`, intra-letter gap = `0`. No trailing gap is stored.
  - Each letter has a left-aligned 16-bit pattern and a 4-bit length L (1..13). E = `1` with L=1. J, Q and Y have L=13.
- States:
  - IDLE: `Busy` = 0, `DotDashOut` = 0.
  - SEND: shifts out the MSB of the pattern.
  - GAP: exists only when the macro in Configuration is defined.
- IDLE → SEND on `Start`=1 with `Letter` < 26.
  - The pattern, L and the bit counter are loaded from `Letter` on that edge.
  - `Letter` is not observed again until the next accepted `Start`.
- `Start` with `Letter` ≥ 26 is ignored: the block stays in IDLE and no `Done` pulse is produced.
- `Start` while `Busy` is ignored, and the letter in flight is unaffected.
- In SEND:
  - The rate-divider counter runs from DIV-1 down to 0.
  - At 0 with bits remaining: shift the pattern left by one, decrement the remaining-bit count, reload DIV-1, and pulse `NewBitOut`.
  - At 0 on the last bit: go to IDLE (or GAP when the macro is defined).
- Done cycle: `Done` = 1, `Busy` = 0 and `DotDashOut` = 0 in the first IDLE cycle. A `Start` in that cycle is accepted normally, so letters can run back to back.
- `Reset` at any time, including mid-letter: at the next edge the state is IDLE, and all outputs and counters are 0. `Reset` has priority over `Start`.

## Timing
- Reset values: `DotDashOut`, `NewBitOut`, `Busy` and `Done` are all 0.
- `Start` accepted at edge t:
  - `Busy` = 1, `NewBitOut` = 1 and `DotDashOut` = pattern bit 15, all registered, are visible in cycle t+1.
- Bit k (0-based) occupies cycles t+1+k·DIV … t+(k+1)·DIV. Each bit is held exactly DIV cycles.
- `NewBitOut` is high only in cycle t+1+k·DIV.
- `Done` is high in cycle t+1+L·DIV.
- With the macro defined, add 3·DIV cycles before `Done`.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `MORSE_LETTER_GAP_EN`:
  - Defined: after the last pattern bit, enter GAP. GAP emits 3 bit periods of `DotDashOut` = 0, pulsing `NewBitOut` at the start of each. `Busy` stays high throughout. `Done` follows GAP, so back-to-back letters are spaced per the Morse standard.
  - Undefined: GAP state and its logic are absent, and `Done` follows the last pattern bit directly.

## Structure
- `morse_pkg` holds:
  - `MORSE_PATTERN_W` = 16 and `MORSE_LEN_W` = 4.
  - `MORSE_NUM_LETTERS` = 26.
  - `MORSE_GAP_BITS` = 3.
  - The `state_e` enum (IDLE, SEND, GAP).
  - A constant pattern/length lookup function indexed by letter.
- Sub-module `morse_rate_divider`: parametrised by DIV, with `ClockIn`, `Reset`, a `load` input and a `tick` output. `tick` is high when the count is 0. It is instantiated once.

## Test plan
All scenarios use `CLOCK_FREQUENCY`=8 and `BITS_PER_SECOND`=2, so DIV=4.
- Letter A, pattern `10111`, L=5, Start at t:
  - `DotDashOut` reads 1,0,1,1,1, with each bit held 4 cycles.
  - `NewBitOut` pulses at t+1, t+5, t+9, t+13 and t+17.
  - `Done` pulses at t+21, and `Busy` is high from t+1 to t+20.
- Letter E (4), Start at t: `DotDashOut` = 1 for t+1..t+4, then `Done` at t+5.
- Letter C started, `Start` with Letter=4 pulsed mid-letter: the C pattern `11101011101` completes unchanged, and only one `Done` pulse occurs.
- `Letter`=27 with `Start`: `Busy` and `Done` stay 0 for 20 cycles.
- Start A, then `Reset` at t+7: all outputs are 0 from t+8. A new `Start` at t+9 sends a full A.
- Start A, with a second Start (Letter=E) in A's `Done` cycle: E's first `NewBitOut` follows one cycle later, with no idle gap. With `MORSE_LETTER_GAP_EN` defined, A's `Done` moves to t+33.

Source files
------------

// File: rtl/morse_letter_tx_pkg.sv
// Shared widths, FSM state type and the A-Z Morse pattern/length table
// for the Morse letter transmitter.
package morse_pkg;

  localparam int MORSE_PATTERN_W   = 16;
  localparam int MORSE_LEN_W       = 4;
  localparam int MORSE_LETTER_W    = 5;
  localparam int MORSE_NUM_LETTERS = 26;
  localparam int MORSE_GAP_BITS    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [MORSE_PATTERN_W-1:0] pattern;
    logic [MORSE_LEN_W-1:0]     len;
  } morse_code_t;

  // Table holds right-aligned keying bits; the result is left-aligned so SEND
  // always shifts out of the MSB.
  function automatic morse_code_t morse_lookup(input logic [MORSE_LETTER_W-1:0] letter);
    morse_code_t raw;
    morse_code_t result;
    case (letter)
      5'd0:    raw = {16'b10111,         4'd5};
      5'd1:    raw = {16'b111010101,     4'd9};
      5'd2:    raw = {16'b11101011101,   4'd11};
      5'd3:    raw = {16'b1110101,       4'd7};
      5'd4:    raw = {16'b1,             4'd1};
      5'd5:    raw = {16'b101011101,     4'd9};
      5'd6:    raw = {16'b111011101,     4'd9};
      5'd7:    raw = {16'b1010101,       4'd7};
      5'd8:    raw = {16'b101,           4'd3};
      5'd9:    raw = {16'b1011101110111, 4'd13};
      5'd10:   raw = {16'b111010111,     4'd9};
      5'd11:   raw = {16'b101110101,     4'd9};
      5'd12:   raw = {16'b1110111,       4'd7};
      5'd13:   raw = {16'b11101,         4'd5};
      5'd14:   raw = {16'b11101110111,   4'd11};
      5'd15:   raw = {16'b10111011101,   4'd11};
      5'd16:   raw = {16'b1110111010111, 4'd13};
      5'd17:   raw = {16'b1011101,       4'd7};
      5'd18:   raw = {16'b10101,         4'd5};
      5'd19:   raw = {16'b111,           4'd3};
      5'd20:   raw = {16'b1010111,       4'd7};
      5'd21:   raw = {16'b101010111,     4'd9};
      5'd22:   raw = {16'b101110111,     4'd9};
      5'd23:   raw = {16'b11101010111,   4'd11};
      5'd24:   raw = {16'b1110101110111, 4'd13};
      5'd25:   raw = {16'b11101110101,   4'd11};
      default: raw = {16'b0,             4'd1};
    endcase
    result.len     = raw.len;
    result.pattern = raw.pattern << (MORSE_PATTERN_W - int'(raw.len));
    return result;
  endfunction

endpackage

// File: rtl/morse_letter_tx_if.sv
// Request/keying bundle between the key front end and the Morse transmitter.
interface morse_letter_tx_if;

  logic                               Start;
  logic [morse_pkg::MORSE_LETTER_W-1:0] Letter;
  logic                               DotDashOut;
  logic                               NewBitOut;
  logic                               Busy;
  logic                               Done;

  modport master (
    output Start, Letter,
    input  DotDashOut, NewBitOut, Busy, Done
  );

  modport slave (
    input  Start, Letter,
    output DotDashOut, NewBitOut, Busy, Done
  );

endinterface

// File: rtl/morse_letter_tx_rate_divider.sv
// Bit-period down-counter: tick marks the last cycle of a bit period.
module morse_rate_divider #(
  parameter int DIV = 4
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic load,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

  logic [CW-1:0] count;

  // Parks at zero when not reloaded, so an idle transmitter sits quietly.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(DIV - 1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/morse_letter_tx.sv
// Morse letter transmitter: keys one A-Z letter per accepted Start.
// Define MORSE_LETTER_GAP_EN to append a 3-bit silent letter gap before Done.
module morse_letter_tx
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int BITS_PER_SECOND = 2
) (
  input  logic              ClockIn,
  input  logic              Reset,
  morse_letter_tx_if.slave  bus
);

  localparam int DIV = CLOCK_FREQUENCY / BITS_PER_SECOND;

  if (DIV < 2) begin : g_div_check
    $error("morse_letter_tx: CLOCK_FREQUENCY / BITS_PER_SECOND must be at least 2");
  end

  state_e                     state_q, state_n;
  logic [MORSE_PATTERN_W-1:0] shift_q, shift_n;
  logic [MORSE_LEN_W-1:0]     bits_left_q, bits_left_n;
  logic                       dot_q, dot_n;
  logic                       new_bit_q, new_bit_n;
  logic                       busy_q, busy_n;
  logic                       done_q, done_n;
  logic                       load;
  logic                       tick;
  morse_code_t                code;

`ifdef MORSE_LETTER_GAP_EN
  logic [1:0]                 gap_left_q, gap_left_n;
`endif

  morse_rate_divider #(.DIV(DIV)) u_rate_divider (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .load    (load),
    .tick    (tick)
  );

  assign code = morse_lookup(bus.Letter);

  // Every output is computed one cycle ahead and registered below, so the
  // keyed output never sees Start/Letter combinationally.
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    bits_left_n = bits_left_q;
    load        = 1'b0;
    dot_n       = 1'b0;
    new_bit_n   = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
`ifdef MORSE_LETTER_GAP_EN
    gap_left_n  = gap_left_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Start && (bus.Letter < MORSE_LETTER_W'(MORSE_NUM_LETTERS))) begin
          state_n     = SEND;
          shift_n     = code.pattern;
          bits_left_n = code.len - MORSE_LEN_W'(1);
          load        = 1'b1;
          dot_n       = code.pattern[MORSE_PATTERN_W-1];
          new_bit_n   = 1'b1;
          busy_n      = 1'b1;
        end
      end
      SEND: begin
        busy_n = 1'b1;
        dot_n  = shift_q[MORSE_PATTERN_W-1];
        if (tick) begin
          if (bits_left_q != '0) begin
            shift_n     = shift_q << 1;
            bits_left_n = bits_left_q - MORSE_LEN_W'(1);
            load        = 1'b1;
            dot_n       = shift_q[MORSE_PATTERN_W-2];
            new_bit_n   = 1'b1;
          end else begin
`ifdef MORSE_LETTER_GAP_EN
            state_n    = GAP;
            gap_left_n = 2'(MORSE_GAP_BITS - 1);
            load       = 1'b1;
            dot_n      = 1'b0;
            new_bit_n  = 1'b1;
`else
            state_n = IDLE;
            dot_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
`endif
          end
        end
      end
`ifdef MORSE_LETTER_GAP_EN
      GAP: begin
        busy_n = 1'b1;
        if (tick) begin
          if (gap_left_q != '0) begin
            gap_left_n = gap_left_q - 2'd1;
            load       = 1'b1;
            new_bit_n  = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Reset wins over any pending Start and clears the letter in flight.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bits_left_q <= '0;
      dot_q       <= 1'b0;
      new_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MORSE_LETTER_GAP_EN
      gap_left_q  <= '0;
`endif
    end else begin
      state_q     <= state_n;
      shift_q     <= shift_n;
      bits_left_q <= bits_left_n;
      dot_q       <= dot_n;
      new_bit_q   <= new_bit_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
`ifdef MORSE_LETTER_GAP_EN
      gap_left_q  <= gap_left_n;
`endif
    end
  end

  assign bus.DotDashOut = dot_q;
  assign bus.NewBitOut  = new_bit_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;

endmodule

// File: tb/tb_morse_letter_tx.sv
// Directed testbench for morse_letter_tx at DIV=4 using a table of letters
// plus hand-written sequences for reset, busy-ignore and back-to-back cases.
module tb_morse_letter_tx;

  localparam int CLK_FREQ = 8;
  localparam int BPS      = 2;
  localparam int DIV      = CLK_FREQ / BPS;
`ifdef MORSE_LETTER_GAP_EN
  localparam int GAP_BITS = 3;
`else
  localparam int GAP_BITS = 0;
`endif

  typedef struct {
    string       name;
    logic [4:0]  code;
    logic [15:0] pat;
    int          len;
  } vec_t;

  logic ClockIn = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  morse_letter_tx_if bus();

  morse_letter_tx #(
    .CLOCK_FREQUENCY (CLK_FREQ),
    .BITS_PER_SECOND (BPS)
  ) dut (
    .ClockIn (ClockIn),
    .Reset   (rst),
    .bus     (bus)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic stepCycle();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] l, input logic r);
    bus.Start  = s;
    bus.Letter = l;
    rst        = r;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [3:0] want);
    logic [3:0] got;
    got = {bus.DotDashOut, bus.NewBitOut, bus.Busy, bus.Done};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: dot/new/busy/done got %b, required %b",
               name, cyc, got, want);
    end
  endtask

  // Expected {dot,new,busy,done} in cycle c after Start was accepted;
  // pat holds the keying bits right-aligned, first bit sent is pat[len-1].
  function automatic logic [3:0] expectedAt(input int c, input logic [15:0] pat, input int len);
    int total;
    logic nb;
    total = (len + GAP_BITS) * DIV;
    nb    = ((c - 1) % DIV) == 0;
    if (c >= 1 && c <= len * DIV)
      return {pat[len - 1 - (c - 1) / DIV], nb, 1'b1, 1'b0};
    else if (c >= 1 && c <= total)
      return {1'b0, nb, 1'b1, 1'b0};
    else if (c == total + 1)
      return 4'b0001;
    return 4'b0000;
  endfunction

  // Caller has already driven Start in the current cycle.
  task automatic runLetter(input string name, input logic [15:0] pat, input int len,
                           input int poke_cycle, input logic [4:0] poke_letter,
                           input bit chain, input logic [4:0] next_letter);
    int last;
    last = (len + GAP_BITS) * DIV + 1;
    for (int c = 1; c <= last; c++) begin
      stepCycle();
      applyStimulus(1'b0, 5'd0, 1'b0);
      if (c == poke_cycle) applyStimulus(1'b1, poke_letter, 1'b0);
      if (chain && c == last) applyStimulus(1'b1, next_letter, 1'b0);
      checkOutput(name, c, expectedAt(c, pat, len));
    end
  endtask

  task automatic checkIdle(input string name, input int n);
    for (int c = 1; c <= n; c++) begin
      stepCycle();
      applyStimulus(1'b0, 5'd0, 1'b0);
      checkOutput(name, c, 4'b0000);
    end
  endtask

  initial begin
    vecs[0] = '{"A", 5'd0,  16'b10111,         5};
    vecs[1] = '{"E", 5'd4,  16'b1,             1};
    vecs[2] = '{"C", 5'd2,  16'b11101011101,   11};
    vecs[3] = '{"J", 5'd9,  16'b1011101110111, 13};
    vecs[4] = '{"T", 5'd19, 16'b111,           3};
    vecs[5] = '{"Q", 5'd16, 16'b1110111010111, 13};
    vecs[6] = '{"Y", 5'd24, 16'b1110101110111, 13};
    vecs[7] = '{"Z", 5'd25, 16'b11101110101,   11};

    applyStimulus(1'b0, 5'd0, 1'b1);
    stepCycle();
    checkOutput("reset_state", 0, 4'b0000);
    stepCycle();
    checkOutput("reset_state", 1, 4'b0000);
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkIdle("post_reset_idle", 2);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].code, 1'b0);
      runLetter({"letter_", vecs[i].name}, vecs[i].pat, vecs[i].len, 0, 5'd0, 1'b0, 5'd0);
      checkIdle({"after_", vecs[i].name}, 1);
    end

    // Start(E) while C is in flight must not disturb C or add a Done.
    applyStimulus(1'b1, 5'd2, 1'b0);
    runLetter("busy_ignore_C", 16'b11101011101, 11, 6, 5'd4, 1'b0, 5'd0);
    checkIdle("busy_ignore_tail", 12);

    applyStimulus(1'b1, 5'd27, 1'b0);
    checkIdle("invalid_27", 20);
    applyStimulus(1'b1, 5'd26, 1'b0);
    checkIdle("invalid_26", 6);
    applyStimulus(1'b1, 5'd31, 1'b0);
    checkIdle("invalid_31", 6);

    // Reset in cycle t+7 of an A, then a fresh A started at t+9.
    applyStimulus(1'b1, 5'd0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      stepCycle();
      applyStimulus(1'b0, 5'd0, (c == 7));
      checkOutput("reset_mid_A", c, expectedAt(c, 16'b10111, 5));
    end
    stepCycle();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("reset_mid_cleared", 8, 4'b0000);
    stepCycle();
    checkOutput("reset_mid_cleared", 9, 4'b0000);
    applyStimulus(1'b1, 5'd0, 1'b0);
    runLetter("after_reset_A", 16'b10111, 5, 0, 5'd0, 1'b0, 5'd0);
    checkIdle("after_reset_tail", 2);

    // A then E launched in A's Done cycle.
    applyStimulus(1'b1, 5'd0, 1'b0);
    runLetter("b2b_A", 16'b10111, 5, 0, 5'd0, 1'b1, 5'd4);
    runLetter("b2b_E", 16'b1, 1, 0, 5'd0, 1'b0, 5'd0);
    checkIdle("b2b_tail", 2);

    // Reset takes priority over a simultaneous Start.
    applyStimulus(1'b1, 5'd0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("reset_priority", 1, 4'b0000);
    checkIdle("reset_priority_tail", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
